// File: rtl/npc_bpred.sv
// Next-PC generator with a direct-mapped BTB and 2-bit saturating direction counters.
// Optional statistics counters (br_count/miss_count) are enabled by defining BP_STATS_EN.
module npc_bpred #(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned TAG_W    = 8,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    input  logic        jal_id,
    input  logic [31:0] jal_target_id,
    input  logic        jalr_ex,
    input  logic [31:0] jalr_target_ex,
    input  logic        br_ex,
    input  logic        taken_ex,
    input  logic [31:0] target_ex,
    input  logic [31:0] pc_ex,
    input  logic        pred_taken_ex,
    input  logic [31:0] pred_target_ex,
    output logic [31:0] npc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         cnt_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IDX_W-1:0] idx_if, idx_ex;
    logic [TAG_W-1:0] tag_if, tag_ex;
    logic             hit_if, hit_ex;
    logic [31:0]      pc_if_plus4, pc_ex_plus4;
    logic [1:0]       cnt_d;
    logic             unused_pc_bits;

    assign idx_if = pc_if[IDX_W+1:2];
    assign tag_if = pc_if[IDX_W+TAG_W+1:IDX_W+2];
    assign idx_ex = pc_ex[IDX_W+1:2];
    assign tag_ex = pc_ex[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_pc_bits = ^{pc_if, pc_ex};

    assign pc_if_plus4 = pc_if + 32'd4;
    assign pc_ex_plus4 = pc_ex + 32'd4;

    assign hit_if = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

    assign pred_taken  = hit_if && cnt_q[idx_if][1];
    assign pred_target = pred_taken ? target_q[idx_if] : pc_if_plus4;

    assign mispredict = br_ex && ((taken_ex != pred_taken_ex) ||
                        (taken_ex && pred_taken_ex && (pred_target_ex != target_ex)));

    always_comb begin
        if (mispredict && taken_ex)       npc = target_ex;
        else if (mispredict)              npc = pc_ex_plus4;
        else if (jalr_ex)                 npc = jalr_target_ex;
        else if (jal_id)                  npc = jal_target_id;
        else                              npc = pred_target;
    end

    // A miss that is taken allocates weakly-taken; a hit moves the counter with saturation.
    always_comb begin
        cnt_d = cnt_q[idx_ex];
        if (!hit_ex)                        cnt_d = 2'b10;
        else if (taken_ex && cnt_d != 2'b11) cnt_d = cnt_d + 2'd1;
        else if (!taken_ex && cnt_d != 2'b00) cnt_d = cnt_d - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
        end else if (br_ex && (hit_ex || taken_ex)) begin
            valid_q[idx_ex] <= 1'b1;
            cnt_q[idx_ex]   <= cnt_d;
        end
    end

    // Tags and targets need no reset: they are only observed through a valid entry.
    always_ff @(posedge clk) begin
        if (br_ex && taken_ex) begin
            tag_q[idx_ex]    <= tag_ex;
            target_q[idx_ex] <= target_ex;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_count_q, miss_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else if (br_ex) begin
            br_count_q <= br_count_q + 32'd1;
            if (mispredict) miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign br_count   = br_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
